// File: rtl/csa_accumulator_ctrl.sv
// csa_accumulator_ctrl: carry-save accumulator of num_ops operands per job; define CSA_ACCUM_SIGNED_EN for two's-complement operands
module csa_accumulator_ctrl #(
  parameter int width = 8,
  parameter int num_ops = 4,
  localparam int aw = width + $clog2(num_ops)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_valid,
  input  logic [width-1:0] op_data,
  output logic             op_ready,
  output logic             busy,
`ifdef CSA_ACCUM_SIGNED_EN
  output logic signed [aw-1:0] result,
`else
  output logic [aw-1:0]    result,
`endif
  output logic             result_valid,
  input  logic             result_ready
);
  localparam int cw = $clog2(num_ops + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
  state_t state;
  logic [aw-1:0] s, c, x, s_n, c_n;
  logic [cw-1:0] cnt;
  logic last;
`ifdef CSA_ACCUM_SIGNED_EN
  assign x = {{(aw-width){op_data[width-1]}}, op_data};
`else
  assign x = {{(aw-width){1'b0}}, op_data};
`endif
  assign s_n = s ^ c ^ x;
  assign c_n = ((s & c) | (s & x) | (c & x)) << 1;
  assign last = cnt == cw'(num_ops - 1);
  // job sequencing; op_ready/busy/result_valid are registered alongside the state
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      s <= '0;
      c <= '0;
      cnt <= '0;
      result <= '0;
      op_ready <= 1'b0;
      busy <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          s <= '0;
          c <= '0;
          cnt <= '0;
          state <= ACCUM;
          op_ready <= 1'b1;
          busy <= 1'b1;
        end
        ACCUM: if (op_valid) begin
          s <= s_n;
          c <= c_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= RESOLVE;
            op_ready <= 1'b0;
          end
        end
        RESOLVE: begin
          result <= s + c;
          state <= DONE;
          result_valid <= 1'b1;
        end
        DONE: if (result_ready) begin
          state <= IDLE;
          result_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_csa_accumulator_ctrl.sv
// tb_csa_accumulator_ctrl: directed scoreboard bench for csa_accumulator_ctrl (width=8, num_ops=4)
module tb_csa_accumulator_ctrl;
  logic clk = 0, rst = 1, start = 0, op_valid = 0, result_ready = 0;
  logic [7:0] op_data = '0;
  logic op_ready, busy, result_valid;
  logic [9:0] result, res_u, s_snap, c_snap;
  int tests = 0, fails = 0;
  logic [9:0] sb[$];
  csa_accumulator_ctrl #(.width(8), .num_ops(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_data(op_data),
    .op_ready(op_ready), .busy(busy), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );
  assign res_u = result;
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send_op(input logic [7:0] v);
    op_valid = 1;
    op_data = v;
    tick();
    op_valid = 0;
  endtask
  task automatic wait_result(input string tag);
    int n = 0;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, result_valid, 1);
    if (result_valid && sb.size() > 0) check(tag, res_u, sb.pop_front());
  endtask
  task automatic finish_result(input string tag);
    result_ready = 1;
    tick();
    result_ready = 0;
    check({tag, "_rv_clr"}, result_valid, 0);
    check({tag, "_busy_clr"}, busy, 0);
  endtask
  initial begin
    tick();
    tick();
    check("rst_op_ready", op_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_result", res_u, 0);
    rst = 0;
    // 1,2,3,4 back to back, latency check
    sb.push_back(10'd10);
    do_start();
    check("accum_op_ready", op_ready, 1);
    check("accum_busy", busy, 1);
    send_op(8'd1);
    send_op(8'd2);
    send_op(8'd3);
    send_op(8'd4);
    check("resolve_op_ready", op_ready, 0);
    check("rv_early", result_valid, 0);
    tick();
    check("rv_latency", result_valid, 1);
    wait_result("sum_1234");
    finish_result("job1");
    check("result_hold_idle", res_u, 10'd10);
    // 255 x4 with a 3-cycle gap after the second operand
    sb.push_back(10'h3FC);
    do_start();
    send_op(8'hFF);
    send_op(8'hFF);
    s_snap = dut.s;
    c_snap = dut.c;
    check("gap_s_model", s_snap, 10'h000);
    check("gap_c_model", c_snap, 10'h1FE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_s_hold", dut.s, s_snap);
      check("gap_c_hold", dut.c, c_snap);
      check("gap_op_ready", op_ready, 1);
    end
    send_op(8'hFF);
    send_op(8'hFF);
    wait_result("sum_ff_x4");
    finish_result("job2");
    // DONE back-pressure with start pulses ignored
    sb.push_back(10'd34);
    do_start();
    send_op(8'd7);
    send_op(8'd8);
    send_op(8'd9);
    send_op(8'd10);
    wait_result("sum_7_10");
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      check("done_result_stable", res_u, 10'd34);
      check("done_op_ready", op_ready, 0);
      check("done_rv", result_valid, 1);
    end
    start = 1;
    finish_result("job3");
    start = 0;
    tick();
    check("start_not_queued", busy, 0);
    // op_valid in IDLE is ignored
    op_valid = 1;
    op_data = 8'd99;
    tick();
    tick();
    op_valid = 0;
    check("idle_op_ignored_busy", busy, 0);
    check("idle_op_ready", op_ready, 0);
    // reset mid-job, then a fresh job
    do_start();
    send_op(8'd3);
    send_op(8'd3);
    rst = 1;
    start = 1;
    tick();
    rst = 0;
    start = 0;
    check("midrst_op_ready", op_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rv", result_valid, 0);
    check("midrst_result", res_u, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_pulse", result_valid, 0);
    end
    sb.push_back(10'd20);
    do_start();
    send_op(8'd5);
    send_op(8'd5);
    send_op(8'd5);
    send_op(8'd5);
    wait_result("sum_5x4");
    finish_result("job4");
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
